// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, icache request, redirects and a decoupling fetch FIFO toward decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BUF_DEPTH = 4,
  parameter int          BUF_AW    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] fetch_addr,
  output logic        fetch_req,
  input  logic        inst_available,
  input  logic [31:0] inst,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  input  logic        predict_fail,
  input  logic [31:0] fail_addr,
  input  logic        jalr_compute,
  input  logic [31:0] jalr_addr,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_stall,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred
);

  localparam logic [6:0]      OPC_JAL   = 7'b1101111;
  localparam logic [6:0]      OPC_JALR  = 7'b1100111;
  localparam logic [BUF_AW:0] DEPTH_CNT = (BUF_AW + 1)'(BUF_DEPTH);

  typedef enum logic {
    S_FETCH,
    S_WAIT_JALR
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [BUF_AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [BUF_AW:0]     count_q, count_d;

  logic [31:0]         buf_pc_q   [BUF_DEPTH];
  logic [31:0]         buf_inst_q [BUF_DEPTH];
  logic                buf_pred_q [BUF_DEPTH];

  logic                full;
  logic                accept;
  logic                push_en;
  logic                pop_en;
  logic [31:0]         jal_imm;

  assign full       = (count_q == DEPTH_CNT);
  assign fetch_addr = pc_q;
  assign fetch_req  = !rst_in && (state_q == S_FETCH) && !full;
  assign accept     = fetch_req && inst_available;

  assign out_valid  = !rst_in && (count_q != '0);
  assign out_inst   = buf_inst_q[head_q];
  assign out_pc     = buf_pc_q[head_q];
  assign out_pred   = buf_pred_q[head_q];

  // A pause or a flush suppresses both FIFO ports for the cycle.
  assign push_en = rdy_in && !predict_fail && accept;
  assign pop_en  = rdy_in && !predict_fail && out_valid && out_ready;

  assign jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (rdy_in) begin
      if (predict_fail) begin
        pc_d    = fail_addr;
        state_d = S_FETCH;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_en) tail_d = tail_q + 1'b1;
        if (pop_en)  head_d = head_q + 1'b1;
        count_d = count_q + {{BUF_AW{1'b0}}, push_en} - {{BUF_AW{1'b0}}, pop_en};

        unique case (state_q)
          S_FETCH: begin
            if (accept) begin
              if (inst[6:0] == OPC_JALR) begin
                state_d = S_WAIT_JALR;
              end else if (branch) begin
                pc_d = branch_addr;
              end else if (inst[6:0] == OPC_JAL) begin
                pc_d = pc_q + jal_imm;
              end else begin
                pc_d = pc_q + 32'd4;
              end
            end
          end
          S_WAIT_JALR: begin
            if (jalr_compute) begin
              pc_d    = jalr_addr;
              state_d = S_FETCH;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      buf_pc_q[tail_q]   <= pc_q;
      buf_inst_q[tail_q] <= inst;
      buf_pred_q[tail_q] <= branch;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_flush_q, perf_stall_q;
  logic        stall_cond;

  // A fetch stall is either waiting on a JALR target or being unable to fetch because the FIFO is full.
  assign stall_cond = (state_q == S_WAIT_JALR) || ((state_q == S_FETCH) && full);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_fetched_q <= '0;
      perf_flush_q   <= '0;
      perf_stall_q   <= '0;
    end else if (rdy_in) begin
      if (push_en)      perf_fetched_q <= perf_fetched_q + 32'd1;
      if (predict_fail) perf_flush_q   <= perf_flush_q + 32'd1;
      if (stall_cond)   perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flush   = perf_flush_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: table-driven stream vectors plus JALR, flush and reset sequences.
module tb_inst_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        inst_available;
  logic [31:0] inst;
  logic        branch;
  logic [31:0] branch_addr;
  logic        predict_fail;
  logic [31:0] fail_addr;
  logic        jalr_compute;
  logic [31:0] jalr_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  inst_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(4), .BUF_AW(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .fetch_addr     (fetch_addr),
    .fetch_req      (fetch_req),
    .inst_available (inst_available),
    .inst           (inst),
    .branch         (branch),
    .branch_addr    (branch_addr),
    .predict_fail   (predict_fail),
    .fail_addr      (fail_addr),
    .jalr_compute   (jalr_compute),
    .jalr_addr      (jalr_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred       (out_pred)
  );

  typedef struct {
    logic        ia;
    logic [31:0] inst;
    logic        br;
    logic [31:0] baddr;
    logic        ordy;
    logic        pf;
    logic [31:0] faddr;
    logic        rdy;
    logic [31:0] e_fa;
    logic        e_freq;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_pred;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] JAL_P20  = 32'h020000EF;  // jal x1, +0x20
  localparam logic [31:0] JAL_M8   = 32'hFF9FF0EF;  // jal x1, -8
  localparam logic [31:0] JALR_W   = 32'h000080E7;  // jalr x1, 0(x1)

  // ADDI word tagged with its own PC so head entries are distinguishable.
  function automatic logic [31:0] addi(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    inst_available = 1'b0;
    inst           = 32'h0;
    branch         = 1'b0;
    branch_addr    = 32'h0;
    predict_fail   = 1'b0;
    fail_addr      = 32'h0;
    jalr_compute   = 1'b0;
    jalr_addr      = 32'h0;
    out_ready      = 1'b0;
    rdy_in         = 1'b1;
  endtask

  task automatic add(input logic ia, input logic [31:0] in_w, input logic br, input logic [31:0] baddr,
                     input logic ordy, input logic pf, input logic [31:0] faddr, input logic rdy,
                     input logic [31:0] e_fa, input logic e_freq, input logic e_ov,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_pred);
    vec_t v;
    v = '{ia, in_w, br, baddr, ordy, pf, faddr, rdy, e_fa, e_freq, e_ov, e_pc, e_inst, e_pred};
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill to full with decode stalled, then drain with order kept.
    add(1, addi(32'h0),  0, 0, 0, 0, 0, 1, 32'h4,  1, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'h4),  0, 0, 0, 0, 0, 1, 32'h8,  1, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'h8),  0, 0, 0, 0, 0, 1, 32'hC,  1, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'hC),  0, 0, 0, 0, 0, 1, 32'h10, 0, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'h10), 0, 0, 0, 0, 0, 1, 32'h10, 0, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'h10), 0, 0, 0, 0, 0, 1, 32'h10, 0, 1, 32'h0,  addi(32'h0),  0);
    add(1, addi(32'h10), 0, 0, 1, 0, 0, 1, 32'h10, 1, 1, 32'h4,  addi(32'h4),  0);
    add(1, addi(32'h10), 0, 0, 1, 0, 0, 1, 32'h14, 1, 1, 32'h8,  addi(32'h8),  0);
    add(0, 32'h0,        0, 0, 1, 0, 0, 1, 32'h14, 1, 1, 32'hC,  addi(32'hC),  0);
    add(0, 32'h0,        0, 0, 1, 0, 0, 1, 32'h14, 1, 1, 32'h10, addi(32'h10), 0);
    add(0, 32'h0,        0, 0, 1, 0, 0, 1, 32'h14, 1, 0, 32'h0,  32'h0,        0);
    // Streaming, one per cycle.
    add(1, addi(32'h14), 0, 0, 1, 0, 0, 1, 32'h18, 1, 1, 32'h14, addi(32'h14), 0);
    add(1, addi(32'h18), 0, 0, 1, 0, 0, 1, 32'h1C, 1, 1, 32'h18, addi(32'h18), 0);
    add(1, addi(32'h1C), 0, 0, 1, 0, 0, 1, 32'h20, 1, 1, 32'h1C, addi(32'h1C), 0);
    add(0, 32'h0,        0, 0, 1, 0, 0, 1, 32'h20, 1, 0, 32'h0,  32'h0,        0);
    // JAL forward, predicted branch, JAL backward.
    add(1, JAL_P20,      0, 0,        1, 0, 0, 1, 32'h40,  1, 1, 32'h20,  JAL_P20,      0);
    add(1, addi(32'h40), 1, 32'h100,  1, 0, 0, 1, 32'h100, 1, 1, 32'h40,  addi(32'h40), 1);
    add(0, 32'h0,        0, 0,        1, 0, 0, 1, 32'h100, 1, 0, 32'h0,   32'h0,        0);
    add(1, JAL_M8,       0, 0,        1, 0, 0, 1, 32'hF8,  1, 1, 32'h100, JAL_M8,       0);
    add(0, 32'h0,        0, 0,        1, 0, 0, 1, 32'hF8,  1, 0, 32'h0,   32'h0,        0);
    // PC wrap at the top of the address space.
    add(0, 32'h0,              0, 0, 1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, 32'h0,        32'h0,              0);
    add(1, addi(32'hFFFFFFFC), 0, 0, 1, 0, 0,            1, 32'h0,        1, 1, 32'hFFFFFFFC, addi(32'hFFFFFFFC), 0);
    add(0, 32'h0,              0, 0, 1, 0, 0,            1, 32'h0,        1, 0, 32'h0,        32'h0,              0);
    // Pause mid-stream: hits, pops and even a flush are held off while rdy_in=0.
    add(1, addi(32'h0), 0, 0, 0, 0, 0,        1, 32'h4, 1, 1, 32'h0, addi(32'h0), 0);
    add(1, addi(32'h4), 0, 0, 0, 0, 0,        1, 32'h8, 1, 1, 32'h0, addi(32'h0), 0);
    add(1, addi(32'h8), 0, 0, 1, 0, 0,        0, 32'h8, 1, 1, 32'h0, addi(32'h0), 0);
    add(1, addi(32'h8), 0, 0, 1, 1, 32'h500, 0, 32'h8, 1, 1, 32'h0, addi(32'h0), 0);
    add(1, addi(32'h8), 0, 0, 1, 0, 0,        1, 32'hC, 1, 1, 32'h4, addi(32'h4), 0);
    add(0, 32'h0,       0, 0, 1, 0, 0,        1, 32'hC, 1, 1, 32'h8, addi(32'h8), 0);
    add(0, 32'h0,       0, 0, 1, 0, 0,        1, 32'hC, 1, 0, 32'h0, 32'h0,       0);

    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    check("reset fetch_req", {31'b0, fetch_req}, 32'h0);
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    rst_in = 1'b0;
    #1;
    check("post-reset fetch_addr", fetch_addr, 32'h0);
    check("post-reset fetch_req", {31'b0, fetch_req}, 32'h1);
    check("post-reset out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk_in);

    for (int i = 0; i < vq.size(); i++) begin
      inst_available = vq[i].ia;
      inst           = vq[i].inst;
      branch         = vq[i].br;
      branch_addr    = vq[i].baddr;
      out_ready      = vq[i].ordy;
      predict_fail   = vq[i].pf;
      fail_addr      = vq[i].faddr;
      rdy_in         = vq[i].rdy;
      tick();
      check($sformatf("v%0d fetch_addr", i), fetch_addr, vq[i].e_fa);
      check($sformatf("v%0d fetch_req", i), {31'b0, fetch_req}, {31'b0, vq[i].e_freq});
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].e_ov});
      if (vq[i].e_ov) begin
        check($sformatf("v%0d out_pc", i), out_pc, vq[i].e_pc);
        check($sformatf("v%0d out_inst", i), out_inst, vq[i].e_inst);
        check($sformatf("v%0d out_pred", i), {31'b0, out_pred}, {31'b0, vq[i].e_pred});
      end
    end

    // JALR at 0x40: wait for the resolved target with fetch suppressed.
    idle_inputs();
    predict_fail = 1'b1;
    fail_addr    = 32'h40;
    tick();
    check("redirect to 0x40", fetch_addr, 32'h40);
    predict_fail   = 1'b0;
    inst_available = 1'b1;
    inst           = JALR_W;
    tick();
    check("jalr fetch_addr holds", fetch_addr, 32'h40);
    check("jalr fetch_req", {31'b0, fetch_req}, 32'h0);
    check("jalr pushed pc", out_pc, 32'h40);
    check("jalr pushed inst", out_inst, JALR_W);
    inst = addi(32'h40);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wait_jalr%0d fetch_req", k), {31'b0, fetch_req}, 32'h0);
      check($sformatf("wait_jalr%0d fetch_addr", k), fetch_addr, 32'h40);
    end
    jalr_compute = 1'b1;
    jalr_addr    = 32'h200;
    tick();
    check("jalr resolved fetch_addr", fetch_addr, 32'h200);
    check("jalr resolved fetch_req", {31'b0, fetch_req}, 32'h1);
    inst_available = 1'b0;
    out_ready      = 1'b1;
    jalr_addr      = 32'h300;
    tick();
    check("jalr_compute ignored in FETCH", fetch_addr, 32'h200);
    check("single jalr entry drained", {31'b0, out_valid}, 32'h0);

    // Flush with three buffered entries and a same-cycle hit and pop.
    idle_inputs();
    inst_available = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst = addi(32'h200 + 32'(4 * k));
      tick();
    end
    check("three buffered fetch_addr", fetch_addr, 32'h20C);
    check("three buffered head", out_pc, 32'h200);
    inst         = addi(32'h20C);
    out_ready    = 1'b1;
    predict_fail = 1'b1;
    fail_addr    = 32'h80;
    tick();
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    check("flush fetch_addr", fetch_addr, 32'h80);
    check("flush fetch_req", {31'b0, fetch_req}, 32'h1);
    predict_fail = 1'b0;
    out_ready    = 1'b0;
    inst         = addi(32'h80);
    tick();
    check("after flush head pc", out_pc, 32'h80);
    check("after flush fetch_addr", fetch_addr, 32'h84);

    // Reset while the FIFO holds data.
    rst_in = 1'b1;
    tick();
    check("mid-run reset out_valid", {31'b0, out_valid}, 32'h0);
    check("mid-run reset fetch_req", {31'b0, fetch_req}, 32'h0);
    check("mid-run reset fetch_addr", fetch_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
